// File: rtl/fetch_queue.sv
// fetch_queue: elastic {pc, instr} buffer between fetch and decode.
// Circular buffer of DEPTH entries with wrap-around pointers and a separate
// occupancy counter one bit wider than the pointers. Ready and valid are
// derived from the counter alone, so neither side sees a combinational path
// from the other. A redirect flush empties the queue and outranks any push or
// pop issued in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [ILEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [ILEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = XLEN + ILEN;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  // Handshake flags come only from the counter (and reset for the input side).
  assign in_ready  = resetn && (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Head entry is zeroed whenever the queue is empty so decode never sees stale data.
  assign head      = mem[rd_ptr];
  assign out_pc    = out_valid ? head[EW-1:ILEN] : '0;
  assign out_instr = out_valid ? head[ILEN-1:0]  : '0;
  assign occupancy = count;

  // Storage array: written on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_pc, in_instr};
    end
  end

  // Pointer and counter control; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: vector table, corner-case sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;

  logic            clk;
  logic            resetn;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [ILEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  logic [2:0]      occupancy;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of {pc, instr} in program order.
  logic [63:0] mq[$];

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ordy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic [2:0]  eocc;
    logic        erdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rn, logic fl, logic iv, logic [31:0] pc,
                              logic [31:0] ins, logic ordy, logic ev,
                              logic [31:0] epc, logic [31:0] ein,
                              logic [2:0] eocc, logic erdy);
    vec_t v;
    v.rn = rn; v.fl = fl; v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy;
    v.ev = ev; v.epc = epc; v.ein = ein; v.eocc = eocc; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, clock the DUT and compare.
  task automatic step(input logic rn, input logic fl, input logic iv,
                      input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
    bit          pre_rdy;
    bit          pre_vld;
    logic [63:0] hd;
    resetn = rn; flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    #1;
    pre_rdy = rn && (mq.size() < DEPTH);
    pre_vld = (mq.size() != 0);
    chk("in_ready_pre", {63'd0, in_ready}, {63'd0, pre_rdy});
    if (!rn || fl) begin
      mq.delete();
    end else begin
      if (pre_vld && ordy) void'(mq.pop_front());
      if (pre_rdy && iv) mq.push_back({pc, ins});
    end
    @(posedge clk);
    #1;
    hd = (mq.size() != 0) ? mq[0] : 64'd0;
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
    chk("occupancy", {61'd0, occupancy}, 64'(mq.size()));
    chk("in_ready", {63'd0, in_ready}, {63'd0, rn && (mq.size() < DEPTH)});
    chk("out_pc", {32'd0, out_pc}, {32'd0, hd[63:32]});
    chk("out_instr", {32'd0, out_instr}, {32'd0, hd[31:0]});
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;

    // Reset, single push with hold, fill to full, refused push, ordered drain.
    tbl.push_back(mk(0,0,0,32'h0,32'h0,0, 0,32'h0,32'h0,3'd0,0));
    tbl.push_back(mk(0,0,0,32'h0,32'h0,0, 0,32'h0,32'h0,3'd0,0));
    tbl.push_back(mk(1,0,0,32'h0,32'h0,0, 0,32'h0,32'h0,3'd0,1));
    tbl.push_back(mk(1,0,1,32'h0,32'h01908093,0, 1,32'h0,32'h01908093,3'd1,1));
    tbl.push_back(mk(1,0,0,32'h0,32'h0,0, 1,32'h0,32'h01908093,3'd1,1));
    tbl.push_back(mk(1,0,0,32'h0,32'h0,0, 1,32'h0,32'h01908093,3'd1,1));
    tbl.push_back(mk(1,0,0,32'h0,32'h0,1, 0,32'h0,32'h0,3'd0,1));
    tbl.push_back(mk(1,0,1,32'h0,32'h01908093,0, 1,32'h0,32'h01908093,3'd1,1));
    tbl.push_back(mk(1,0,1,32'h4,32'h04b10113,0, 1,32'h0,32'h01908093,3'd2,1));
    tbl.push_back(mk(1,0,1,32'h8,32'h002080b3,0, 1,32'h0,32'h01908093,3'd3,1));
    tbl.push_back(mk(1,0,1,32'hC,32'h40208133,0, 1,32'h0,32'h01908093,3'd4,0));
    tbl.push_back(mk(1,0,1,32'h10,32'hdeadbeef,0, 1,32'h0,32'h01908093,3'd4,0));
    tbl.push_back(mk(1,0,0,32'h0,32'h0,1, 1,32'h4,32'h04b10113,3'd3,1));
    tbl.push_back(mk(1,0,0,32'h0,32'h0,1, 1,32'h8,32'h002080b3,3'd2,1));
    tbl.push_back(mk(1,0,0,32'h0,32'h0,1, 1,32'hC,32'h40208133,3'd1,1));
    tbl.push_back(mk(1,0,0,32'h0,32'h0,1, 0,32'h0,32'h0,3'd0,1));

    foreach (tbl[i]) begin
      step(tbl[i].rn, tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].ordy);
      chk($sformatf("tbl%0d_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_pc", i), {32'd0, out_pc}, {32'd0, tbl[i].epc});
      chk($sformatf("tbl%0d_instr", i), {32'd0, out_instr}, {32'd0, tbl[i].ein});
      chk($sformatf("tbl%0d_occ", i), {61'd0, occupancy}, {61'd0, tbl[i].eocc});
      chk($sformatf("tbl%0d_rdy", i), {63'd0, in_ready}, {63'd0, tbl[i].erdy});
    end

    // Streaming with out_ready=1 across several pointer wraps.
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1);
      chk("stream_occ", {61'd0, occupancy}, 64'd1);
      chk("stream_pc", {32'd0, out_pc}, {32'd0, 32'h100 + 32'(4 * i)});
    end
    step(1, 0, 0, 32'h0, 32'h0, 1);
    chk("stream_drained", {63'd0, out_valid}, 64'd0);

    // Flush with a same-cycle push and pop: both are dropped.
    step(1, 0, 1, 32'h20, 32'h11, 0);
    step(1, 0, 1, 32'h24, 32'h22, 0);
    step(1, 0, 1, 32'h28, 32'h33, 0);
    chk("pre_flush_occ", {61'd0, occupancy}, 64'd3);
    step(1, 1, 1, 32'h40, 32'h44, 1);
    chk("flush_occ", {61'd0, occupancy}, 64'd0);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_rdy", {63'd0, in_ready}, 64'd1);
    step(1, 0, 1, 32'h80, 32'h88, 0);
    chk("post_flush_pc", {32'd0, out_pc}, {32'd0, 32'h80});
    chk("post_flush_occ", {61'd0, occupancy}, 64'd1);
    step(1, 0, 0, 32'h0, 32'h0, 1);
    chk("post_flush_empty", {63'd0, out_valid}, 64'd0);

    // Reset mid-stream with two entries queued.
    step(1, 0, 1, 32'h200, 32'h1, 0);
    step(1, 0, 1, 32'h204, 32'h2, 0);
    resetn = 1'b0; in_valid = 1'b1;
    #1;
    chk("rst_in_ready_comb", {63'd0, in_ready}, 64'd0);
    step(0, 0, 1, 32'h208, 32'h3, 1);
    chk("rst_rdy0", {63'd0, in_ready}, 64'd0);
    step(0, 0, 1, 32'h20C, 32'h4, 0);
    chk("rst_rdy1", {63'd0, in_ready}, 64'd0);
    step(1, 0, 0, 32'h0, 32'h0, 0);
    chk("rst_occ", {61'd0, occupancy}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_rdy_rel", {63'd0, in_ready}, 64'd1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7), $urandom, $urandom,
           ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
